seg7_scanner: RTL and testbench

Time-multiplexed seven-segment display driver that consumes the one-cycle 1 kHz strobe from `pulsegenerator`, the stage directly upstream. Each strobe advances the active digit, so an 8-digit display refreshes at 125 Hz. A 32-bit hex value is captured once per full scan to prevent tearing. The block drives the board's active-low anodes, segments and decimal point directly.

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/hex_to_seg7.sv | 34 +++
 rtl/seg7_scanner.sv | 104 ++++++++++
 tb/tb_seg7_scanner.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner: segment encodings, blank pattern, sizing.
// Latency: n/a (package).  Backpressure: n/a (package).
// Segment encodings are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int MAX_DIGITS = 8;
    localparam int IDX_W      = 3;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Hex nibble to active-low seven-segment pattern decoder.
// Latency: purely combinational.  Backpressure: none.
// Ports: nib (4-bit hex digit in), seg (active-low {g..a} out).
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scanner.sv
// Time-multiplexed seven-segment driver; each tick strobe advances one digit, value captured once per scan.
// Latency: an/seg/dp/digit_idx update on the edge that samples tick=1, all from registers.
// Backpressure: none; every tick is consumed, ticks on consecutive cycles each advance the scan.
// Ports: clk, rst (async active-high), tick, value[4*N], dp_in[N] in; an[N], seg[7], dp, digit_idx[3] out.
// Build option: define SEG7_LZ_BLANK_EN for leading-zero blanking of digits above digit 0.
module seg7_scanner
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [IDX_W-1:0]        digit_idx
);

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dp;

    logic                    reload;
    logic [IDX_W-1:0]        nidx;
    logic [4*NUM_DIGITS-1:0] src_val;
    logic [NUM_DIGITS-1:0]   src_dp;
    logic [3:0]              nib;
    logic                    nib_dp;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              seg_dec;
    logic                    lit;

    // Next digit and its source. On a reload tick (first tick out of IDLE, or
    // wrap) the digit is taken straight from the inputs being captured so the
    // first digit of a scan already reflects the fresh value.
    always_comb begin
        reload  = (state == IDLE) || (idx == IDX_W'(NUM_DIGITS - 1));
        nidx    = reload ? '0 : idx + 1'b1;
        src_val = reload ? value : shadow_val;
        src_dp  = reload ? dp_in : shadow_dp;
        nib     = 4'h0;
        nib_dp  = 1'b0;
        an_next = '1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (nidx == IDX_W'(j)) begin
                nib        = src_val[4*j +: 4];
                nib_dp     = src_dp[j];
                an_next[j] = 1'b0;
            end
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    logic upper_nz;

    // A digit is shown if it is digit 0 or any nibble at or above it is non-zero.
    always_comb begin
        upper_nz = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((IDX_W'(j) >= nidx) && (src_val[4*j +: 4] != 4'h0)) begin
                upper_nz = 1'b1;
            end
        end
        lit = (nidx == '0) || upper_nz;
    end
`else
    assign lit = 1'b1;
`endif

    hex_to_seg7 u_dec (
        .nib (nib),
        .seg (seg_dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            an         <= '1;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
        end else if (tick) begin
            state <= SCAN;
            idx   <= nidx;
            if (reload) begin
                shadow_val <= value;
                shadow_dp  <= dp_in;
            end
            an  <= lit ? an_next : '1;
            seg <= lit ? seg_dec : SEG_BLANK;
            dp  <= ~(lit & nib_dp);
        end
    end

    assign digit_idx = idx;

endmodule

// File: tb/tb_seg7_scanner.sv
// Self-checking bench for seg7_scanner with a behavioural scan model.
// Latency: outputs checked one cycle after each tick.  Backpressure: n/a.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_seg7_scanner;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic [31:0] value = 32'h0;
    logic [7:0]  dp_in = 8'h0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [2:0]  digit_idx;

    logic [18:0] obs;
    logic [18:0] exp_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] hex_lut [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Model state: whether scanning, current digit, captured value and dp bits.
    bit          m_running;
    int          m_idx;
    logic [31:0] m_val;
    logic [7:0]  m_dp;

    seg7_scanner #(.NUM_DIGITS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .value     (value),
        .dp_in     (dp_in),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .digit_idx (digit_idx)
    );

    always #5 clk = ~clk;

    assign obs = {an, seg, dp, digit_idx};

    task automatic model_reset();
        m_running = 1'b0;
        m_idx     = 0;
        m_val     = 32'h0;
        m_dp      = 8'h0;
    endtask

    task automatic model_tick();
        if (!m_running) begin
            m_running = 1'b1;
            m_idx     = 0;
        end else begin
            m_idx = (m_idx + 1) % N;
        end
        if (m_idx == 0) begin
            m_val = value;
            m_dp  = dp_in;
        end
    endtask

    function automatic logic [18:0] model_out();
        bit blank;
        logic [31:0] upper;
        if (!m_running) return {8'hFF, 7'h7F, 1'b1, 3'd0};
        upper = m_val >> (4 * m_idx);
        blank = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
        blank = (m_idx > 0) && (upper == 32'h0);
`endif
        if (blank) return {8'hFF, 7'h7F, 1'b1, 3'(m_idx)};
        return {~(8'h01 << m_idx), hex_lut[upper[3:0]], ~m_dp[m_idx], 3'(m_idx)};
    endfunction

    // One-cycle strobe; starts and ends on a falling edge, model advanced after the edge.
    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        model_tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            value = $urandom;
            dp_in = 8'($urandom);
            @(negedge clk);
            exp_o = model_out();
            n_checks++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d: got %h, expected %h", c, obs, exp_o);
            end
        end
    endtask

    task automatic test_scan();
        value = 32'h8765_4321;
        dp_in = 8'h04;
        for (int t = 0; t < 8; t++) begin
            pulse_tick();
            exp_o = model_out();
            n_checks++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL scan t=%0d: got %h, expected %h", t, obs, exp_o);
            end
            n_checks++;
            if ((dp === 1'b0) !== (an === 8'hFB)) begin
                n_fail++;
                $display("FAIL scan_dp t=%0d: dp=%b an=%h, dp low only with an=FB", t, dp, an);
            end
            // Holding between strobes: outputs must not move.
            repeat ($urandom_range(0, 3)) begin
                value = $urandom;
                @(negedge clk);
                n_checks++;
                if (obs !== exp_o) begin
                    n_fail++;
                    $display("FAIL scan_hold t=%0d: got %h, expected %h", t, obs, exp_o);
                end
            end
            value = 32'h8765_4321;
        end
    endtask

    task automatic test_tear();
        value = $urandom;
        dp_in = 8'($urandom);
        // Model ends test_scan on digit 7; the first tick here wraps to a new scan.
        for (int t = 0; t < 8; t++) begin
            if (t == 3) value = 32'hFFFF_FFFF;
            pulse_tick();
            exp_o = model_out();
            n_checks++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL tear t=%0d: got %h, expected %h", t, obs, exp_o);
            end
        end
        pulse_tick();
        n_checks++;
        if (seg !== 7'b0001110 || an !== 8'hFE) begin
            n_fail++;
            $display("FAIL tear_wrap: seg=%b an=%h, expected seg=0001110 an=fe", seg, an);
        end
    endtask

    task automatic test_reset_mid();
        for (int t = 0; t < 2 * N && m_idx != 5; t++) pulse_tick();
        tick = 1'b1;
        rst  = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (obs !== {8'hFF, 7'h7F, 1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_async: got %h, expected %h", obs, {8'hFF, 7'h7F, 1'b1, 3'd0});
        end
        @(negedge clk);
        tick  = 1'b0;
        rst   = 1'b0;
        value = 32'h1357_9BDF;
        dp_in = 8'h01;
        @(negedge clk);
        n_checks++;
        if (obs !== {8'hFF, 7'h7F, 1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_dominant: got %h, expected blank", obs);
        end
        pulse_tick();
        exp_o = model_out();
        n_checks++;
        if (obs !== exp_o || digit_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_restart: got %h, expected %h", obs, exp_o);
        end
    endtask

    task automatic test_back_to_back();
        value = $urandom;
        dp_in = 8'($urandom);
        tick  = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (t == 9) tick = 1'b0;
            model_tick();
            exp_o = model_out();
            n_checks++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL back_to_back t=%0d: got %h, expected %h", t, obs, exp_o);
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 300; t++) begin
            // Bias towards zero high nibbles so blanking boundaries get exercised.
            value = $urandom >> $urandom_range(0, 31);
            dp_in = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                tick = 1'b1;
                @(negedge clk);
                tick = 1'b0;
                model_tick();
            end else begin
                @(negedge clk);
            end
            exp_o = model_out();
            n_checks++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL random t=%0d: got %h, expected %h", t, obs, exp_o);
            end
        end
    endtask

`ifdef SEG7_LZ_BLANK_EN
    task automatic test_lz_blank();
        logic [31:0] pats [2] = '{32'h0000_00A0, 32'h0000_0000};
        for (int p = 0; p < 2; p++) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            model_reset();
            value = pats[p];
            dp_in = 8'hFF;
            for (int t = 0; t < N; t++) begin
                pulse_tick();
                exp_o = model_out();
                n_checks++;
                if (obs !== exp_o) begin
                    n_fail++;
                    $display("FAIL lz_blank p=%0d t=%0d: got %h, expected %h", p, t, obs, exp_o);
                end
                n_checks++;
                if ((an === 8'hFF) !== (t >= ((p == 0) ? 2 : 1))) begin
                    n_fail++;
                    $display("FAIL lz_slot p=%0d t=%0d: an=%h", p, t, an);
                end
            end
        end
    endtask
`endif

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_scan();
        test_tear();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef SEG7_LZ_BLANK_EN
        test_lz_blank();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
